// File: rtl/memoria_dados_pkg.sv
// Shared definitions for the data memory: funct3 width codes, access size
// classes and the byte-enable / extension constants used by the lane decoder.
package memoria_dados_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[2] set means zero-extend the loaded lane
  localparam int unsigned F3_UNSIGNED_BIT = 2;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  function automatic size_e f3_size(input logic [2:0] f3);
    size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      F3_W:        sz = SZ_WORD;
      default:     sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/memoria_dados_lane.sv
// Lane decoder: byte-enable and store-data replication for stores, lane
// selection plus sign/zero extension for loads. Halfwords use addr_lo[1] and
// words ignore addr_lo, so misaligned low bits are dropped here; the raw
// misalignment is reported separately for the optional trap logic.
module memoria_dados_lane
  import memoria_dados_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        valid,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  size_e       size;
  logic        uns;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Decode width, build enables and extract/extend the addressed lane
  always_comb begin
    size       = f3_size(funct3);
    valid      = (size != SZ_NONE);
    uns        = funct3[F3_UNSIGNED_BIT];
    byte_v     = rword[{addr_lo, 3'b000} +: 8];
    half_v     = addr_lo[1] ? rword[31:16] : rword[15:0];
    be         = '0;
    wlane      = wdata;
    rext       = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = BE_BYTE << addr_lo;
        wlane = {4{wdata[7:0]}};
        rext  = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        be         = BE_HALF << {addr_lo[1], 1'b0};
        wlane      = {2{wdata[15:0]}};
        rext       = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = BE_WORD;
        wlane      = wdata;
        rext       = rword;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memoria_dados.sv
// Data memory: DEPTH_WORDS x 32-bit little-endian store with combinational
// loads, byte/half/word stores, saturating load/store counters.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses are suppressed and
// recorded in err_sticky/err_addr; otherwise misaligned low bits are ignored.
module memoria_dados
  import memoria_dados_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  output logic [31:0]      rdata,
  output logic             misalign,
  output logic             err_sticky,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic             lane_valid;
  logic             lane_mis;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic [31:0]      rext;
  logic             mis_trap;
  logic             load_ok;
  logic             store_ok;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;

  // Upper address bits are dropped, so addresses alias every DEPTH_WORDS*4 bytes
  assign idx   = addr[IDX_W+1:2];
  assign rword = mem_q[idx];

  memoria_dados_lane u_lane (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .rword      (rword),
    .valid      (lane_valid),
    .misaligned (lane_mis),
    .be         (be),
    .wlane      (wlane),
    .rext       (rext)
  );

`ifdef MISALIGN_TRAP_EN
  logic        access;
  logic        err_sticky_q, err_sticky_d;
  logic [31:0] err_addr_q, err_addr_d;

  assign access   = (mem_read | mem_write) & lane_valid;
  assign mis_trap = access & lane_mis;

  // First trap latches its address; later traps only keep the sticky bit set
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    if (mis_trap) begin
      err_sticky_d = 1'b1;
      if (!err_sticky_q) err_addr_d = addr;
    end
  end

  // Error state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;
`else
  logic unused_bits;

  assign mis_trap    = 1'b0;
  assign unused_bits = ^{addr[31:IDX_W+2], lane_mis};
  assign err_sticky  = 1'b0;
  assign err_addr    = '0;
`endif

  assign misalign = mis_trap;
  assign load_ok  = mem_read  & lane_valid & ~mis_trap;
  assign store_ok = mem_write & lane_valid & ~mis_trap;

  // Combinational read: during a simultaneous store this is the pre-store word
  assign rdata = load_ok ? rext : '0;

  // Byte-lane store commit; an edge seen while reset is asserted is dropped
  always_ff @(posedge clk) begin
    if (rst_n && store_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Saturating access counters next-state
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (load_ok  && (load_cnt_q  != '1)) load_cnt_d  = load_cnt_q  + 1'b1;
    if (store_ok && (store_cnt_q != '1)) store_cnt_d = store_cnt_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;

endmodule
